// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter: round-robin scheduler that shares a single FIFO write
// port between REQ_NUM valid/ready producers. A grant is held for a burst of
// up to BURST_MAX words. Every burst is followed by one IDLE cycle in which
// the next owner is chosen.
//
// Handshake: producer i presents req_valid[i] with req_data slice i. The word
// is consumed on a rising edge where req_valid[i] & req_ready[i] is high. A
// producer must hold valid and data stable until that edge. Only the current
// owner ever sees ready. The FIFO side is a plain write strobe that is gated by
// fifo_full, so the FIFO never receives a write while it is full.
//
// grant_valid is high exactly when the FSM is in BURST, so it doubles as the
// externally visible state indication.
module fifo_write_arbiter #(
  parameter int WIDTH     = 8,
  parameter int REQ_NUM   = 4,
  parameter int BURST_MAX = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [REQ_NUM-1:0]       req_valid,
  input  logic [REQ_NUM*WIDTH-1:0] req_data,
  output logic [REQ_NUM-1:0]       req_ready,
  output logic                     fifo_write_req,
  output logic [WIDTH-1:0]         fifo_write_data,
  input  logic                     fifo_full,
  output logic                     grant_valid,
  output logic [$clog2(REQ_NUM)-1:0] grant_id
);

  localparam int ID_W  = $clog2(REQ_NUM);
  localparam int CNT_W = $clog2(BURST_MAX + 1);

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  state_t            state, state_nxt;
  logic [ID_W-1:0]   gid_q, gid_nxt;
  logic [ID_W-1:0]   last_q, last_nxt;
  logic [CNT_W-1:0]  cnt_q, cnt_nxt;

  // Round-robin search result
  logic              pick_found;
  logic [ID_W-1:0]   pick_id;
  int                rr_idx;

  // Owner-side view of the inputs
  logic              own_valid;
  logic [WIDTH-1:0]  own_data;
  logic              xfer;
  logic [CNT_W-1:0]  cnt_inc;
  logic              burst_done;

  // State register; reset puts producer 0 at the head of the rotation
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      gid_q  <= '0;
      last_q <= ID_W'(REQ_NUM - 1);
      cnt_q  <= '0;
    end else begin
      state  <= state_nxt;
      gid_q  <= gid_nxt;
      last_q <= last_nxt;
      cnt_q  <= cnt_nxt;
    end
  end

  // Search upward from last_q+1 with wrap-around for the first requester
  always_comb begin
    pick_found = 1'b0;
    pick_id    = '0;
    rr_idx     = 0;
    for (int k = 1; k <= REQ_NUM; k++) begin
      rr_idx = (int'(last_q) + k) % REQ_NUM;
      if (!pick_found && req_valid[rr_idx[ID_W-1:0]]) begin
        pick_found = 1'b1;
        pick_id    = rr_idx[ID_W-1:0];
      end
    end
  end

  // Select the current owner's valid and data. A loop compare keeps the
  // mux legal for REQ_NUM values that are not a power of two.
  always_comb begin
    own_valid = 1'b0;
    own_data  = '0;
    for (int i = 0; i < REQ_NUM; i++) begin
      if (gid_q == ID_W'(i)) begin
        own_valid = req_valid[i];
        own_data  = req_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // Per-producer ready: only the owner, and only while the FIFO has room
  always_comb begin
    req_ready = '0;
    for (int i = 0; i < REQ_NUM; i++) begin
      req_ready[i] = (state == BURST) && (gid_q == ID_W'(i)) && !fifo_full;
    end
  end

  assign grant_valid     = (state == BURST);
  assign grant_id        = gid_q;
  assign xfer            = grant_valid && own_valid && !fifo_full;
  assign fifo_write_req  = xfer;
  assign fifo_write_data = own_data;
  assign cnt_inc         = cnt_q + CNT_W'(1);
  assign burst_done      = (cnt_inc == CNT_W'(BURST_MAX));

  // Next-state logic: grant in IDLE, then count, stall or release in BURST
  always_comb begin
    state_nxt = state;
    gid_nxt   = gid_q;
    last_nxt  = last_q;
    cnt_nxt   = cnt_q;
    case (state)
      IDLE: begin
        if (pick_found) begin
          gid_nxt   = pick_id;
          cnt_nxt   = '0;
          state_nxt = BURST;
        end
      end
      BURST: begin
        if (!own_valid) begin
          // Owner has nothing to send; this wins even when the FIFO is full.
          last_nxt  = gid_q;
          state_nxt = IDLE;
        end else if (!fifo_full) begin
          if (burst_done) begin
            last_nxt  = gid_q;
            state_nxt = IDLE;
          end else begin
            cnt_nxt = cnt_inc;
          end
        end
        // A full FIFO with the owner still valid holds everything in place.
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: doc/fifo_write_arbiter.md
Name: fifo_write_arbiter

Overview:
- Round-robin write-port scheduler that shares one FIFO write port (fifo_write_req / fifo_write_data / fifo_full) between REQ_NUM producers.
- Each producer uses a valid/ready handshake. A grant is held for a burst of up to BURST_MAX words, then rotates.
- Sits directly in front of fifo_top's write side; the read side of the FIFO is untouched.

Parameters:
- WIDTH, 8, data word width; must equal the FIFO's WIDTH.
- REQ_NUM, 4, number of producers; range 2..16.
- BURST_MAX, 4, maximum words accepted per grant; range 1..255.
- ID_W (localparam), $clog2(REQ_NUM), width of grant_id.
- CNT_W (localparam), $clog2(BURST_MAX+1), width of the burst counter.

Ports:
- clk  input  1  clock; all state on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- req_valid  input  REQ_NUM  bit i = producer i has a word.
- req_data  input  REQ_NUM*WIDTH  producer i data at bits [i*WIDTH +: WIDTH].
- req_ready  output  REQ_NUM  bit i = producer i word accepted this cycle if valid.
- fifo_write_req  output  1  write strobe to FIFO.
- fifo_write_data  output  WIDTH  write data to FIFO.
- fifo_full  input  1  FIFO full flag.
- grant_valid  output  1  a producer currently owns the port.
- grant_id  output  ID_W  index of the owning producer.

Interface fact: one clock; reset is asynchronous and active-high.

Behaviour:
- Reset (rst=1, takes effect immediately, no clock needed):
  - state=IDLE, grant_valid=0, grant_id=0, burst count=0.
  - last-grant pointer=REQ_NUM-1, so producer 0 has top priority first.
  - Consequently req_ready=0 and fifo_write_req=0.
- Combinational outputs:
  - req_ready[i] = grant_valid & (grant_id==i) & ~fifo_full.
  - fifo_write_req = grant_valid & req_valid[grant_id] & ~fifo_full.
  - fifo_write_data = req_data slice selected by grant_id; don't-care when fifo_write_req=0.
  - A transfer occurs on a cycle with fifo_write_req=1; exactly one word is written per transfer.
- State machine, two states:
  - IDLE:
    - grant_valid=0.
    - If any req_valid bit is set, select the first set bit searching from (last pointer+1) mod REQ_NUM upward with wrap-around.
    - Register it into grant_id, set grant_valid=1, clear count, go to BURST.
    - Otherwise stay in IDLE.
  - BURST:
    - On a transfer: count+1. If count+1==BURST_MAX, set last pointer=grant_id, grant_valid=0, go to IDLE.
    - If req_valid[grant_id]=0: release the same way (pointer=grant_id, go to IDLE) with no transfer.
    - If fifo_full=1 and req_valid[grant_id]=1: hold state, count and grant; no transfer. Stalls never end a burst.
- Latency:
  - Request seen in IDLE on cycle N → grant registered at edge N → earliest transfer in cycle N+1.
  - There is one IDLE bubble cycle between consecutive bursts.
- Fairness: a producer that keeps valid high is served within (REQ_NUM-1) bursts plus bubbles.
- Producers requesting in IDLE but not selected are not acknowledged; they must hold valid and data stable until ready.
- Reset asserted mid-burst: state returns to IDLE with pointer=REQ_NUM-1. Any word presented in that cycle is not written; fifo_write_req drops with rst.
- Simultaneous valid drop and fifo_full: treated as release; go to IDLE.
- BURST_MAX=1: every transfer returns to IDLE, giving strict one-word round-robin.

Test Plan:
- Reset, then req_valid=4'b0001 with data 0x11,0x12,… and fifo_full=0 → grant_id=0 from cycle 2. Writes 0x11..0x14 on four consecutive cycles, one IDLE bubble, then the next burst of 4.
- req_valid=4'b1111 held with fifo_full=0 → grant order 0,1,2,3,0. Each grant yields exactly 4 writes; total 20 writes in 25 cycles.
- Producer 2 alone with fifo_full=1 for 3 cycles mid-burst after 2 transfers → req_ready=0 and fifo_write_req=0 for 3 cycles. The burst then resumes with 2 more writes and releases at count 4.
- Producer 1 holds valid for 2 words then drops → release after 2 writes, pointer=1. With 4'b0101 requesting next, producer 2 wins before producer 0.
- Assert rst asynchronously between clock edges during a burst → grant_valid, req_ready and fifo_write_req go to 0 immediately. After release with 4'b1000, the first grant goes to producer 3 because 0..2 are not requesting.
- BURST_MAX=1, REQ_NUM=2, both valid → writes alternate 0,1,0,1 with one bubble between each.
